// File: rtl/cpu_pkg.sv
// Shared pipeline constants: register-address width, $0 index, default data width, trace format.
package cpu_pkg;

  localparam int                REG_AW     = 5;
  localparam logic [REG_AW-1:0] REG_ZERO   = 5'd0;
  localparam int                DW_DEFAULT = 32;
  localparam string             TRACE_FMT  = "@%h: $%d <= %h";

endpackage

// File: rtl/gpr_array.sv
// NREG x DW register storage: one synchronous write port, two asynchronous read ports and a
// synchronous clear. It has no notion of $0 and no bypass; the wrapper handles both.
module gpr_array #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  // NOTE: the clear loop makes this flop storage rather than an inferable RAM macro; the pipeline
  // relies on every register reading 0 after reset, so the clear stays.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/wb_commit_regfile.sv
// Write-back commit stage: GPR file with write-through read bypass, retired counter, last-commit
// record. Define GRF_TRACE_EN to print one judge-format line per committed GPR write.
module wb_commit_regfile
  import cpu_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int DW    = DW_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_regwrite,
  input  logic              wb_memtoreg,
  input  logic [DW-1:0]     wb_aluout,
  input  logic [DW-1:0]     wb_readdata,
  input  logic [REG_AW-1:0] wb_regaddr,
  input  logic [DW-1:0]     wb_pc,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DW-1:0]     rs_data,
  output logic [DW-1:0]     rt_data,
  output logic [CNT_W-1:0]  retired,
  output logic [DW-1:0]     last_pc,
  output logic [REG_AW-1:0] last_addr,
  output logic [DW-1:0]     last_data
);

  localparam int AW = $clog2(NREG);

  logic [DW-1:0] commit_data;
  logic          commit;
  logic          bypass_live;
  logic [DW-1:0] arr_a, arr_b;

  assign commit_data = wb_memtoreg ? wb_readdata : wb_aluout;
  assign commit      = wb_valid && wb_regwrite && (wb_regaddr != REG_ZERO);
  // A commit that coincides with reset is discarded, so it must not be forwarded either.
  assign bypass_live = commit && !rst;

  gpr_array #(.NREG(NREG), .DW(DW), .AW(AW)) u_gpr (
    .clk     (clk),
    .rst     (rst),
    .we      (bypass_live),
    .waddr   (wb_regaddr[AW-1:0]),
    .wdata   (commit_data),
    .raddr_a (rs_addr[AW-1:0]),
    .raddr_b (rt_addr[AW-1:0]),
    .rdata_a (arr_a),
    .rdata_b (arr_b)
  );

  // NOTE: every branch assigns both outputs, so no latch is inferred.
  always_comb begin
    if (bypass_live && rs_addr == wb_regaddr) rs_data = commit_data;
    else if (rs_addr == REG_ZERO)             rs_data = '0;
    else                                      rs_data = arr_a;

    if (bypass_live && rt_addr == wb_regaddr) rt_data = commit_data;
    else if (rt_addr == REG_ZERO)             rt_data = '0;
    else                                      rt_data = arr_b;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired   <= '0;
      last_pc   <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (wb_valid) retired <= retired + 1'b1;
      if (commit) begin
        last_pc   <= wb_pc;
        last_addr <= wb_regaddr;
        last_data <= commit_data;
      end
    end
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (bypass_live) $display(TRACE_FMT, wb_pc, wb_regaddr, commit_data);
  end
`else
`endif

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Directed bench for wb_commit_regfile: an architectural model scored every cycle plus literal pins.
module tb_wb_commit_regfile;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid, wb_regwrite, wb_memtoreg;
  logic [31:0]      wb_aluout, wb_readdata, wb_pc;
  logic [4:0]       wb_regaddr, rs_addr, rt_addr;
  logic [31:0]      rs_data, rt_data, last_pc, last_data;
  logic [CNT_W-1:0] retired;
  logic [4:0]       last_addr;

  int n_cmp = 0;
  int n_err = 0;

  wb_commit_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_aluout(wb_aluout), .wb_readdata(wb_readdata),
    .wb_regaddr(wb_regaddr), .wb_pc(wb_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .retired(retired), .last_pc(last_pc),
    .last_addr(last_addr), .last_data(last_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: what the register file, counter and record must hold.
  logic [31:0]      m_regs [32];
  logic [CNT_W-1:0] m_ret;
  logic [31:0]      m_lpc, m_ldata;
  logic [4:0]       m_laddr;
  logic             preload_ret = 1'b0;
  logic             chk_en = 1'b0;

  function automatic logic [31:0] m_cdata();
    return wb_memtoreg ? wb_readdata : wb_aluout;
  endfunction

  function automatic logic m_commits();
    return wb_valid && wb_regwrite && wb_regaddr != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!rst && m_commits() && a == wb_regaddr) return m_cdata();
    if (a == 5'd0) return 32'd0;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_ret <= '0; m_lpc <= '0; m_laddr <= '0; m_ldata <= '0;
    end else begin
      m_ret <= (preload_ret ? {CNT_W{1'b1}} : m_ret) + (wb_valid ? 1 : 0);
      if (m_commits()) begin
        m_regs[wb_regaddr] <= m_cdata();
        m_lpc <= wb_pc; m_laddr <= wb_regaddr; m_ldata <= m_cdata();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model rs_data", rs_data, m_read(rs_addr));
      check("model rt_data", rt_data, m_read(rt_addr));
      check("model retired", retired, preload_ret ? {CNT_W{1'b1}} : m_ret);
      check("model last_pc", last_pc, m_lpc);
      check("model last_addr", {27'd0, last_addr}, {27'd0, m_laddr});
      check("model last_data", last_data, m_ldata);
    end
  end

  task automatic drive(input logic v, rw, mtr, input logic [31:0] alu, rdd,
                       input logic [4:0] a, input logic [31:0] pc, input logic [4:0] ra, rb);
    wb_valid = v; wb_regwrite = rw; wb_memtoreg = mtr; wb_aluout = alu; wb_readdata = rdd;
    wb_regaddr = a; wb_pc = pc; rs_addr = ra; rt_addr = rb;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;

    // Reset state: every address on both ports reads zero.
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 32'hA5A5_A5A5, 0, 5'(i), 0, 5'(i), 5'(31 - i));
      check("reset rs", rs_data, 32'd0);
      check("reset rt", rt_data, 32'd0);
      tick();
    end
    check("reset retired", retired, 32'd0);
    check("reset last_pc", last_pc, 32'd0);
    check("reset last_data", last_data, 32'd0);

    // $5 <= 1234_5678 via aluout, forwarded in the same cycle on port A.
    drive(1, 1, 0, 32'h1234_5678, 32'hCCCC_CCCC, 5'd5, 32'h0000_3000, 5'd5, 5'd6);
    check("bypass rs $5", rs_data, 32'h1234_5678);
    check("no bypass rt $6", rt_data, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5);
    check("array $5", rs_data, 32'h1234_5678);
    check("last_addr $5", {27'd0, last_addr}, 32'd5);
    check("last_pc $5", last_pc, 32'h0000_3000);
    check("retired 1", retired, 32'd1);
    tick();

    // $0 write: no effect on array or record, still retires.
    drive(1, 1, 0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0000_3004, 5'd0, 5'd0);
    check("$0 no bypass", rs_data, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd5);
    check("$0 reads 0", rs_data, 32'd0);
    check("last_addr held", {27'd0, last_addr}, 32'd5);
    check("last_data held", last_data, 32'h1234_5678);
    check("retired 2", retired, 32'd2);
    tick();

    // Load path into $31.
    drive(1, 1, 1, 32'h0000_0001, 32'hDEAD_BEEF, 5'd31, 32'h0000_3008, 5'd1, 5'd31);
    check("bypass rt $31", rt_data, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd31, 5'd1);
    check("array $31", rs_data, 32'hDEAD_BEEF);
    check("last_pc $31", last_pc, 32'h0000_3008);
    tick();

    // Both ports forwarding the same destination; then a write-after-write.
    drive(1, 1, 0, 32'h0BAD_F00D, 0, 5'd9, 32'h0000_300C, 5'd9, 5'd9);
    check("dual bypass rs", rs_data, 32'h0BAD_F00D);
    check("dual bypass rt", rt_data, 32'h0BAD_F00D);
    tick();
    drive(1, 1, 0, 32'h7777_0000, 0, 5'd9, 32'h0000_3010, 5'd5, 5'd9);
    check("overwrite bypass", rt_data, 32'h7777_0000);
    tick();

    // Counter wrap from all-ones on a valid non-writing instruction.
    force dut.retired = {CNT_W{1'b1}};
    preload_ret = 1'b1;
    drive(1, 0, 0, 32'h1111_1111, 0, 5'd3, 32'h0000_3014, 5'd3, 5'd9);
    release dut.retired;
    tick();
    preload_ret = 1'b0;
    drive(0, 1, 0, 32'h2222_2222, 0, 5'd12, 32'h0000_3018, 5'd12, 5'd3);
    check("retired wrap", retired, 32'd0);
    check("bubble no bypass", rs_data, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd9);
    check("bubble no write", rs_data, 32'd0);
    check("bubble no count", retired, 32'd0);
    check("array $9", rt_data, 32'h7777_0000);
    tick();

    // Seed $7, then reset coinciding with a commit to $7.
    drive(1, 1, 0, 32'hAAAA_AAAA, 0, 5'd7, 32'h0000_301C, 5'd7, 5'd7);
    tick();
    rst = 1'b1;
    drive(1, 1, 0, 32'h5555_5555, 0, 5'd7, 32'h0000_3020, 5'd7, 5'd9);
    check("rst no bypass", rs_data, 32'hAAAA_AAAA);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd31);
    check("rst clears $7", rs_data, 32'd0);
    check("rst clears $31", rt_data, 32'd0);
    check("rst retired", retired, 32'd0);
    check("rst last_addr", {27'd0, last_addr}, 32'd0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
